// File: rtl/alu_iter_seq_if.sv
// Bundle between the EX stage and the iterative MUL/DIVU/REMU sequencer:
// the op request/response side plus the borrowed-ALU handshake.
interface alu_iter_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             alu_req;
    logic             alu_gnt;
    logic [WIDTH-1:0] alu_src_a;
    logic [WIDTH-1:0] alu_src_b;
    logic [1:0]       alu_control;
    logic [WIDTH-1:0] alu_result;

    modport master (
        output start, op, operand_a, operand_b, alu_gnt, alu_result,
        input  busy, done, result, alu_req, alu_src_a, alu_src_b, alu_control
    );

    modport slave (
        input  start, op, operand_a, operand_b, alu_gnt, alu_result,
        output busy, done, result, alu_req, alu_src_a, alu_src_b, alu_control
    );
endinterface

// File: rtl/alu_iter_seq.sv
// Iterative MUL (low word) / DIVU / REMU sequencer that borrows the shared
// add/sub/slt/sltu ALU one step at a time through a req/grant handshake.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start; operands captured on accept
// MUL_STEP | one shift-add bit; ALU requested only when multiplier lsb is 1
// DIV_CMP  | sltu of shifted remainder against divisor
// DIV_SUB  | subtract divisor from shifted remainder, quotient bit = 1
// DONE     | one-cycle done pulse, result valid
module alu_iter_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_iter_seq_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        MUL_STEP,
        DIV_CMP,
        DIV_SUB,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [CNT_W-1:0]   cnt;
    logic               is_rem;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;

    logic               alu_req;
    logic [WIDTH-1:0]   alu_src_a;
    logic [WIDTH-1:0]   alu_src_b;
    logic [1:0]         alu_control;
    logic [WIDTH-1:0]   r_shift;
    logic               div_lt;
    logic               step_ok;
    logic               last;
    logic               div_bit_done;
    logic [WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;

    // The divisor lives in mcand during a division; it is never shifted there.
    always_comb begin
        r_shift     = {rem[WIDTH-2:0], quo[WIDTH-1]};
        alu_req     = 1'b0;
        alu_src_a   = '0;
        alu_src_b   = '0;
        alu_control = 2'b00;
        case (state)
            MUL_STEP: begin
                if (mplier[0]) begin
                    alu_req   = 1'b1;
                    alu_src_a = acc;
                    alu_src_b = mcand;
                end
            end
            DIV_CMP: begin
                alu_req     = 1'b1;
                alu_src_a   = r_shift;
                alu_src_b   = mcand;
                alu_control = 2'b11;
            end
            DIV_SUB: begin
                alu_req     = 1'b1;
                alu_src_a   = r_shift;
                alu_src_b   = mcand;
                alu_control = 2'b01;
            end
            default: ;
        endcase

        step_ok = ~alu_req | bus.alu_gnt;
        last    = (cnt == '0);
        acc_nxt = mplier[0] ? bus.alu_result : acc;

        // A set remainder msb means the true shifted value exceeds 2^WIDTH,
        // so it can never be below the divisor.
        div_lt = ~rem[WIDTH-1] & bus.alu_result[0];
        if (state == DIV_CMP) begin
            rem_nxt      = r_shift;
            quo_nxt      = {quo[WIDTH-2:0], 1'b0};
            div_bit_done = div_lt;
        end else begin
            rem_nxt      = bus.alu_result;
            quo_nxt      = {quo[WIDTH-2:0], 1'b1};
            div_bit_done = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            is_rem   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc    <= '0;
                        rem    <= '0;
                        quo    <= bus.operand_a;
                        mplier <= bus.operand_b;
                        mcand  <= (bus.op == 2'b00) ? bus.operand_a : bus.operand_b;
                        cnt    <= CNT_W'(WIDTH - 1);
                        is_rem <= (bus.op == 2'b10);
                        busy_q <= 1'b1;
                        case (bus.op)
                            2'b00:   state <= MUL_STEP;
                            2'b01,
                            2'b10:   state <= DIV_CMP;
                            default: begin
                                state    <= DONE;
                                done_q   <= 1'b1;
                                result_q <= '0;
                            end
                        endcase
                    end
                end
                MUL_STEP: begin
                    if (step_ok) begin
                        acc    <= acc_nxt;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        if (last) begin
                            state    <= DONE;
                            done_q   <= 1'b1;
                            result_q <= acc_nxt;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                DIV_CMP, DIV_SUB: begin
                    if (bus.alu_gnt) begin
                        if (div_bit_done) begin
                            rem <= rem_nxt;
                            quo <= quo_nxt;
                            if (last) begin
                                state    <= DONE;
                                done_q   <= 1'b1;
                                result_q <= is_rem ? rem_nxt : quo_nxt;
                            end else begin
                                cnt   <= cnt - CNT_W'(1);
                                state <= DIV_CMP;
                            end
                        end else begin
                            state <= DIV_SUB;
                        end
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.alu_req     = alu_req;
    assign bus.alu_src_a   = alu_src_a;
    assign bus.alu_src_b   = alu_src_b;
    assign bus.alu_control = alu_control;

endmodule
